memory_access_unit: RTL

Load/store unit between the core's data-memory port and a word-wide, byte-enabled data RAM with a request/acknowledge handshake. It converts byte, halfword and word accesses at any byte address into one or two aligned word transactions, and performs lane steering and sign/zero extension. It returns a done pulse to the core's pipeline state controller, which uses it to leave memReadState.

---
 rtl/memory_access_unit.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/memory_access_unit.sv
// Load/store unit: splits byte/half/word accesses into 1-2 aligned, byte-enabled word beats.
// Latency: beat request 1 cycle after the core request; done/result 1 cycle after the last memAck.
// Backpressure: a beat holds until memAck or MAX_WAIT cycles; held core requests wait in RELEASE.
module memory_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   coreAddress,
  input  logic [DATA_WIDTH-1:0]   coreDataWrite,
  input  logic [1:0]              coreLength,
  input  logic                    coreLoad,
  input  logic                    coreStore,
  input  logic                    coreLoadUnsigned,
  output logic [DATA_WIDTH-1:0]   coreDataRead,
  output logic                    coreDone,
  output logic                    coreError,
  output logic [DATA_WIDTH-1:0]   memAddress,
  output logic [DATA_WIDTH-1:0]   memWriteData,
  output logic [DATA_WIDTH/8-1:0] memByteEnable,
  output logic                    memWrite,
  output logic                    memRequest,
  input  logic                    memAck,
  input  logic [DATA_WIDTH-1:0]   memReadData
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RELEASE} state_t;

  state_t                    state, stateNext;
  logic [DATA_WIDTH-1:0]     baseR, baseNext;
  logic [2*DATA_WIDTH-1:0]   wideR, wideNext;
  logic [2*LANES-1:0]        en8R, en8Next;
  logic [1:0]                offR, offNext;
  logic [1:0]                lenR, lenNext;
  logic                      isLoadR, isLoadNext;
  logic                      unsignedR, unsignedNext;
  logic [7:0]                waitCnt, waitNext;
  logic [2*DATA_WIDTH-1:0]   bufR, bufNext;

  logic [DATA_WIDTH-1:0]     coreDataReadNext;
  logic                      coreDoneNext, coreErrorNext;
  logic [DATA_WIDTH-1:0]     memAddressNext, memWriteDataNext;
  logic [LANES-1:0]          memByteEnableNext;
  logic                      memWriteNext, memRequestNext;

  logic [LANES-1:0]          inMask;
  logic [2*LANES-1:0]        inEn8;
  logic [2*DATA_WIDTH-1:0]   inWide;
  logic [DATA_WIDTH-1:0]     raw, loadResult;
  logic                      splitR;

  // Request-side lane steering, computed straight from the core inputs.
  always_comb begin
    inMask = '0;
    case (coreLength)
      2'd0:    inMask = 4'b0001;
      2'd1:    inMask = 4'b0011;
      default: inMask = 4'b1111;
    endcase
    inEn8  = {{LANES{1'b0}}, inMask} << coreAddress[1:0];
    inWide = {{DATA_WIDTH{1'b0}}, coreDataWrite} << {coreAddress[1:0], 3'b000};
  end

  assign splitR = |en8R[2*LANES-1:LANES];

  // Read buffer update and the load result it yields on the final ack.
  always_comb begin
    bufNext = bufR;
    if (memAck && !isLoadR) begin
      bufNext = bufR;
    end else if (memAck && state == BEAT0) begin
      bufNext[DATA_WIDTH-1:0] = memReadData;
    end else if (memAck && state == BEAT1) begin
      bufNext[2*DATA_WIDTH-1:DATA_WIDTH] = memReadData;
    end
    raw = DATA_WIDTH'(bufNext >> {offR, 3'b000});
    loadResult = raw;
    case (lenR)
      2'd0:    loadResult = {{24{~unsignedR & raw[7]}}, raw[7:0]};
      2'd1:    loadResult = {{16{~unsignedR & raw[15]}}, raw[15:0]};
      default: loadResult = raw;
    endcase
  end

  always_comb begin
    stateNext         = state;
    baseNext          = baseR;
    wideNext          = wideR;
    en8Next           = en8R;
    offNext           = offR;
    lenNext           = lenR;
    isLoadNext        = isLoadR;
    unsignedNext      = unsignedR;
    waitNext          = waitCnt;
    coreDataReadNext  = coreDataRead;
    coreDoneNext      = 1'b0;
    coreErrorNext     = 1'b0;
    memAddressNext    = memAddress;
    memWriteDataNext  = memWriteData;
    memByteEnableNext = memByteEnable;
    memWriteNext      = memWrite;
    memRequestNext    = memRequest;

    case (state)
      IDLE: begin
        if (coreLoad || coreStore) begin
          if ((coreLoad && coreStore) || coreLength == 2'd3) begin
            coreErrorNext = 1'b1;
            stateNext     = RELEASE;
          end else begin
            baseNext          = {coreAddress[DATA_WIDTH-1:2], 2'b00};
            wideNext          = inWide;
            en8Next           = inEn8;
            offNext           = coreAddress[1:0];
            lenNext           = coreLength;
            isLoadNext        = coreLoad;
            unsignedNext      = coreLoadUnsigned;
            waitNext          = '0;
            memAddressNext    = {coreAddress[DATA_WIDTH-1:2], 2'b00};
            memWriteDataNext  = inWide[DATA_WIDTH-1:0];
            memByteEnableNext = inEn8[LANES-1:0];
            memWriteNext      = coreStore;
            memRequestNext    = 1'b1;
            stateNext         = BEAT0;
          end
        end
      end
      BEAT0, BEAT1: begin
        if (memAck) begin
          if (state == BEAT0 && splitR) begin
            // Second beat: next word, wrapping at the top of the address space.
            waitNext          = '0;
            memAddressNext    = baseR + DATA_WIDTH'(4);
            memWriteDataNext  = wideR[2*DATA_WIDTH-1:DATA_WIDTH];
            memByteEnableNext = en8R[2*LANES-1:LANES];
            stateNext         = BEAT1;
          end else begin
            memRequestNext = 1'b0;
            coreDoneNext   = 1'b1;
            if (isLoadR) begin
              coreDataReadNext = loadResult;
            end
            stateNext = RELEASE;
          end
        end else if (waitCnt == WAIT_LAST) begin
          memRequestNext = 1'b0;
          coreErrorNext  = 1'b1;
          stateNext      = RELEASE;
        end else begin
          waitNext = waitCnt + 8'd1;
        end
      end
      RELEASE: begin
        if (!coreLoad && !coreStore) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      baseR         <= '0;
      wideR         <= '0;
      en8R          <= '0;
      offR          <= '0;
      lenR          <= '0;
      isLoadR       <= 1'b0;
      unsignedR     <= 1'b0;
      waitCnt       <= '0;
      bufR          <= '0;
      coreDataRead  <= '0;
      coreDone      <= 1'b0;
      coreError     <= 1'b0;
      memAddress    <= '0;
      memWriteData  <= '0;
      memByteEnable <= '0;
      memWrite      <= 1'b0;
      memRequest    <= 1'b0;
    end else begin
      state         <= stateNext;
      baseR         <= baseNext;
      wideR         <= wideNext;
      en8R          <= en8Next;
      offR          <= offNext;
      lenR          <= lenNext;
      isLoadR       <= isLoadNext;
      unsignedR     <= unsignedNext;
      waitCnt       <= waitNext;
      bufR          <= bufNext;
      coreDataRead  <= coreDataReadNext;
      coreDone      <= coreDoneNext;
      coreError     <= coreErrorNext;
      memAddress    <= memAddressNext;
      memWriteData  <= memWriteDataNext;
      memByteEnable <= memByteEnableNext;
      memWrite      <= memWriteNext;
      memRequest    <= memRequestNext;
    end
  end

endmodule
